// File: rtl/native_bus_pkg.sv
// Shared constants, FSM encoding and request record for the picorv32 native-bus memory slave.
package native_bus_pkg;

    localparam int          NB_DATA_W    = 32;
    localparam int          NB_STRB_W    = 4;
    localparam logic [31:0] NB_ERR_RDATA = 32'hDEAD_BEEF;

    // ST_GAP is the cycle mem_ready is visible; the core is still reacting, so valid is ignored.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } nb_state_e;

    typedef struct packed {
        logic [29:0]          waddr;
        logic [NB_DATA_W-1:0] wdata;
        logic [NB_STRB_W-1:0] wstrb;
    } nb_req_t;

endpackage

// File: rtl/nb_byte_ram.sv
// Single-port word RAM built from independent byte lanes; synchronous read-before-write.
module nb_byte_ram
    import native_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_en,
    input  logic [AW-1:0]        i_addr,
    input  logic [NB_STRB_W-1:0] i_we,
    input  logic [NB_DATA_W-1:0] i_wdata,
    output logic [NB_DATA_W-1:0] o_rdata
);

    for (genvar b = 0; b < NB_STRB_W; b++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (i_en && i_we[b]) r_mem[i_addr] <= i_wdata[8*b +: 8];
        end

        // Output register is reset so the bus sees 0 out of reset; the array itself is not.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)   r_q <= 8'h00;
            else if (i_en) r_q <= r_mem[i_addr];
        end

        assign o_rdata[8*b +: 8] = r_q;
    end

endmodule

// File: rtl/native_mem_wait_slave.sv
// Native-bus memory slave with programmable wait states, byte strobes and out-of-range bus error.
module native_mem_wait_slave
    import native_bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          AW          = 8,
    parameter int          WAIT_W      = 4,
    parameter logic [31:0] ERR_RDATA   = NB_ERR_RDATA
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [WAIT_W-1:0]    wait_cfg,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    input  logic [31:0]          mem_addr,
    input  logic [NB_DATA_W-1:0] mem_wdata,
    input  logic [NB_STRB_W-1:0] mem_wstrb,
    output logic                 mem_ready,
    output logic [NB_DATA_W-1:0] mem_rdata,
    output logic                 bus_err
);

    nb_state_e            r_state, w_next;
    logic [WAIT_W-1:0]    r_cnt, w_cnt_next;
    nb_req_t              r_req;
    logic                 r_ready, r_err, r_err_sel;
    logic                 w_accept, w_in_range, w_resp;
    logic                 w_ram_en;
    logic [NB_STRB_W-1:0] w_ram_we;
    logic [NB_DATA_W-1:0] w_ram_q;
    logic                 w_unused;

    assign w_unused   = &{1'b0, mem_instr, mem_addr[1:0]};
    assign w_in_range = (r_req.waddr < 30'(DEPTH_WORDS));
    assign w_resp     = (r_state == ST_RESP);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_valid) begin
                    w_accept   = 1'b1;
                    w_cnt_next = wait_cfg;
                    w_next     = (wait_cfg != '0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!mem_valid)                w_next = ST_IDLE;
                else if (r_cnt == WAIT_W'(1))  w_next = ST_RESP;
                else                           w_cnt_next = r_cnt - WAIT_W'(1);
            end
            ST_RESP: w_next = ST_GAP;
            ST_GAP:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_req     <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_err_sel <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) r_req <= '{waddr: mem_addr[31:2], wdata: mem_wdata, wstrb: mem_wstrb};
            r_ready <= w_resp;
            r_err   <= w_resp && !w_in_range;
            // Sticky select keeps mem_rdata stable until the next response.
            if (w_resp) r_err_sel <= !w_in_range;
        end
    end

    // Memory is touched only in RESP, so aborted or out-of-range accesses never write.
    assign w_ram_en = w_resp && w_in_range;
    assign w_ram_we = w_ram_en ? r_req.wstrb : '0;

    nb_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .i_en    (w_ram_en),
        .i_addr  (r_req.waddr[AW-1:0]),
        .i_we    (w_ram_we),
        .i_wdata (r_req.wdata),
        .o_rdata (w_ram_q)
    );

    assign mem_ready = r_ready;
    assign bus_err   = r_err;
    assign mem_rdata = r_err_sel ? ERR_RDATA : w_ram_q;

endmodule

// File: tb/tb_native_mem_wait_slave.sv
// Directed bench: vector table of bus accesses plus abort, reset and burst sequences.
module tb_native_mem_wait_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  wait_cfg;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, bus_err;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    native_mem_wait_slave dut (
        .clk       (clk),
        .resetn    (resetn),
        .wait_cfg  (wait_cfg),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  wcfg;
        bit          scr;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete access; lat counts edges from the accepting edge (inclusive) to ready.
    task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                             input logic [3:0] wc, input bit scr,
                             output logic [31:0] rd, output logic er, output int lat);
        @(posedge clk); #1;
        wait_cfg = wc; mem_addr = a; mem_wdata = wd; mem_wstrb = st; mem_valid = 1'b1;
        mem_instr = ~mem_instr;
        lat = 0; rd = '0; er = 1'b0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (mem_ready) begin
                rd = mem_rdata; er = bus_err;
                break;
            end
            if (scr && lat == 1) begin
                mem_addr = ~a; mem_wdata = ~wd; wait_cfg = 4'hF;
            end
            if (lat >= 40) begin
                n_tests++; n_fail++;
                $display("FAIL timeout: no mem_ready after %0d cycles (addr %h)", lat, a);
                break;
            end
        end
        mem_valid = 1'b0;
        @(posedge clk); #1;
        chk("ready pulse width", {31'd0, mem_ready}, 32'd0);
        chk("bus_err pulse width", {31'd0, bus_err}, 32'd0);
        chk("rdata hold", mem_rdata, rd);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          seen;

    initial begin
        vt[0]  = '{32'd800,       32'h0102_0304, 4'hF, 4'd0, 1'b0, 1'b0, 32'h0,          1'b0};
        vt[1]  = '{32'd800,       32'h0,         4'h0, 4'd0, 1'b0, 1'b1, 32'h0102_0304, 1'b0};
        vt[2]  = '{32'd956,       32'h1112_1314, 4'hF, 4'd1, 1'b0, 1'b0, 32'h0,          1'b0};
        vt[3]  = '{32'd956,       32'hAABB_CCDD, 4'h5, 4'd2, 1'b0, 1'b1, 32'h1112_1314, 1'b0};
        vt[4]  = '{32'd956,       32'h0,         4'h0, 4'd0, 1'b0, 1'b1, 32'h11BB_13DD, 1'b0};
        vt[5]  = '{32'd800,       32'h0,         4'h0, 4'd5, 1'b1, 1'b1, 32'h0102_0304, 1'b0};
        vt[6]  = '{32'd976,       32'h0BAD_F00D, 4'hF, 4'd0, 1'b0, 1'b0, 32'h0,          1'b0};
        vt[7]  = '{32'd1024,      32'h0,         4'h0, 4'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vt[8]  = '{32'd2000,      32'hCAFE_F00D, 4'hF, 4'd1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vt[9]  = '{32'd976,       32'h0,         4'h0, 4'd0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0};
        vt[10] = '{32'd1020,      32'h5A5A_5A5A, 4'hF, 4'd0, 1'b0, 1'b0, 32'h0,          1'b0};
        vt[11] = '{32'd1023,      32'h0,         4'h0, 4'd1, 1'b0, 1'b1, 32'h5A5A_5A5A, 1'b0};
        vt[12] = '{32'd0,         32'h1234_5678, 4'hF, 4'd0, 1'b0, 1'b0, 32'h0,          1'b0};
        vt[13] = '{32'd0,         32'h9900_AA00, 4'hA, 4'd3, 1'b1, 1'b1, 32'h1234_5678, 1'b0};
        vt[14] = '{32'd2,         32'h0,         4'h0, 4'd2, 1'b0, 1'b1, 32'h9934_AA78, 1'b0};
        vt[15] = '{32'hFFFF_FFFC, 32'h0,         4'h0, 4'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1};

        resetn = 1'b0; wait_cfg = '0; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        #23;
        chk("reset ready", {31'd0, mem_ready}, 32'd0);
        chk("reset rdata", mem_rdata, 32'd0);
        chk("reset bus_err", {31'd0, bus_err}, 32'd0);
        @(negedge clk); resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_access(vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].wcfg, vt[i].scr, rd, er, lat);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].wcfg) + 32'd2);
            chk($sformatf("v%0d bus_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
            if (vt[i].chk_rd) chk($sformatf("v%0d rdata", i), rd, vt[i].exp_rd);
        end

        // Abort: write with 4 wait states, valid dropped after two cycles.
        do_access(32'd400, 32'h1357_2468, 4'hF, 4'd0, 1'b0, rd, er, lat);
        @(posedge clk); #1;
        wait_cfg = 4'd4; mem_addr = 32'd400; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
        mem_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (mem_ready) seen = 1'b1;
        end
        chk("abort no ready", {31'd0, seen}, 32'd0);
        do_access(32'd400, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, lat);
        chk("abort ram unchanged", rd, 32'h1357_2468);

        // Reset asserted mid-wait.
        do_access(32'd800, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, lat);
        @(posedge clk); #1;
        wait_cfg = 4'd6; mem_addr = 32'd800; mem_wstrb = 4'h0; mem_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        #2 resetn = 1'b0;
        #1;
        chk("async reset rdata", mem_rdata, 32'd0);
        chk("async reset ready", {31'd0, mem_ready}, 32'd0);
        chk("async reset bus_err", {31'd0, bus_err}, 32'd0);
        mem_valid = 1'b0;
        @(negedge clk); @(negedge clk); resetn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (mem_ready) seen = 1'b1;
        end
        chk("post-reset no ready", {31'd0, seen}, 32'd0);
        do_access(32'd800, 32'h0, 4'h0, 4'd1, 1'b0, rd, er, lat);
        chk("post-reset read", rd, 32'h0102_0304);

        // 16-word burst with 3 wait states each.
        for (int i = 0; i < 16; i++) begin
            do_access(32'd64 + 32'(4*i), 32'hB000_0000 | 32'(i), 4'hF, 4'd3, 1'b0, rd, er, lat);
            chk($sformatf("burst wr%0d latency", i), 32'(lat), 32'd5);
        end
        for (int i = 0; i < 16; i++) begin
            do_access(32'd64 + 32'(4*i), 32'h0, 4'h0, 4'd3, 1'b0, rd, er, lat);
            chk($sformatf("burst rd%0d latency", i), 32'(lat), 32'd5);
            chk($sformatf("burst rd%0d data", i), rd, 32'hB000_0000 | 32'(i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
